calc1_req_driver: RTL and testbench

CALC1_REQ_DRIVER -- requirements
Module: calc1_req_driver

---
 rtl/calc1_req_pkg.sv | 33 +++
 rtl/calc1_req_timer.sv | 29 ++
 rtl/calc1_req_driver.sv | 127 ++++++++++++
 tb/tb_calc1_req_driver.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc1_req_pkg.sv
// Shared widths, command/response codes and driver state encoding for the
// calc1 request driver.
package calc1_req_pkg;

    localparam int CMD_W   = 4;
    localparam int DATA_W  = 32;
    localparam int RESP_W  = 2;
    localparam int TIMER_W = 16;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 4'b0000,
        CMD_ADD = 4'b0001,
        CMD_SUB = 4'b0010,
        CMD_SLL = 4'b0101,
        CMD_SRL = 4'b0110
    } cmd_e;

    typedef enum logic [RESP_W-1:0] {
        RESP_NONE = 2'b00,
        RESP_OK   = 2'b01,
        RESP_OVF  = 2'b10,
        RESP_ERR  = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND1 = 3'd1,
        ST_SEND2 = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/calc1_req_timer.sv
// WAIT-state cycle counter; restarts from zero whenever the driver is not
// waiting and flags the last permitted WAIT cycle.
module calc1_req_timer
    import calc1_req_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic c_clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!run) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + 1'b1;
        end
    end

    // Expiry is seen during WAIT cycle TIMEOUT_CYCLES-1, so WAIT lasts exactly TIMEOUT_CYCLES cycles.
    assign expired = run && (count == TIMER_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/calc1_req_driver.sv
// Drives one calc1_top request port: two-beat command/operand send, waits for
// the response and holds it until consumed. CALC1_REQ_TIMEOUT_EN adds a WAIT abort.
module calc1_req_driver
    import calc1_req_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [CMD_W-1:0]  op_cmd,
    input  logic [DATA_W-1:0] op_data1,
    input  logic [DATA_W-1:0] op_data2,
    output logic [CMD_W-1:0]  req_cmd_out,
    output logic [DATA_W-1:0] req_data_out,
    input  logic [RESP_W-1:0] calc_resp_in,
    input  logic [DATA_W-1:0] calc_data_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RESP_W-1:0] res_resp,
    output logic [DATA_W-1:0] res_data,
    output logic              res_timeout,
    output logic              busy
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("calc1_req_driver: TIMEOUT_CYCLES must be within 1..65535");
    end

    state_e              state;
    state_e              state_next;
    logic [CMD_W-1:0]    cmd_q;
    logic [DATA_W-1:0]   data1_q;
    logic [DATA_W-1:0]   data2_q;
    logic [RESP_W-1:0]   res_resp_q;
    logic [DATA_W-1:0]   res_data_q;
    logic                res_timeout_q;
    logic                resp_seen;
    logic                timeout_hit;

`ifdef CALC1_REQ_TIMEOUT_EN
    calc1_req_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .c_clk   (c_clk),
        .reset   (reset),
        .run     (state == ST_WAIT),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    assign resp_seen = (calc_resp_in != RESP_NONE);

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (op_valid) begin
                    state_next = (op_cmd == CMD_NOP) ? ST_DONE : ST_SEND1;
                end
            end
            ST_SEND1: state_next = ST_SEND2;
            ST_SEND2: state_next = ST_WAIT;
            ST_WAIT: begin
                if (resp_seen || timeout_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A response arriving on the same cycle as expiry wins over the abort.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cmd_q         <= '0;
            data1_q       <= '0;
            data2_q       <= '0;
            res_resp_q    <= '0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state <= state_next;
            if (op_valid && op_ready) begin
                cmd_q   <= op_cmd;
                data1_q <= op_data1;
                data2_q <= op_data2;
                if (op_cmd == CMD_NOP) begin
                    res_resp_q    <= RESP_NONE;
                    res_data_q    <= '0;
                    res_timeout_q <= 1'b0;
                end
            end
            if (state == ST_WAIT) begin
                if (resp_seen) begin
                    res_resp_q    <= calc_resp_in;
                    res_data_q    <= calc_data_in;
                    res_timeout_q <= 1'b0;
                end else if (timeout_hit) begin
                    res_resp_q    <= RESP_ERR;
                    res_data_q    <= '0;
                    res_timeout_q <= 1'b1;
                end
            end
        end
    end

    assign op_ready     = (state == ST_IDLE) && reset;
    assign busy         = (state != ST_IDLE);
    assign req_cmd_out  = (state == ST_SEND1) ? cmd_q : CMD_NOP;
    assign req_data_out = (state == ST_SEND1) ? data1_q :
                          (state == ST_SEND2) ? data2_q : '0;
    assign res_valid    = (state == ST_DONE);
    assign res_resp     = res_resp_q;
    assign res_data     = res_data_q;
    assign res_timeout  = res_timeout_q;

endmodule

// File: tb/tb_calc1_req_driver.sv
// Bench for calc1_req_driver: the bench plays upstream, calc1_top and
// downstream, and compares against a transaction-level model.
module tb_calc1_req_driver;
    import calc1_req_pkg::*;

`ifdef CALC1_REQ_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif
    localparam int TIMEOUT = 64;
    localparam int BUDGET  = 200;

    logic        c_clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  op_cmd = '0;
    logic [31:0] op_data1 = '0;
    logic [31:0] op_data2 = '0;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  calc_resp_in = '0;
    logic [31:0] calc_data_in = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [1:0]  res_resp;
    logic [31:0] res_data;
    logic        res_timeout;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 c_clk = ~c_clk;

    calc1_req_driver #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .c_clk(c_clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_cmd(op_cmd),
        .op_data1(op_data1), .op_data2(op_data2),
        .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
        .calc_resp_in(calc_resp_in), .calc_data_in(calc_data_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_resp(res_resp),
        .res_data(res_data), .res_timeout(res_timeout), .busy(busy)
    );

    // Transaction-level model: what the calculator would compute, and what the driver must report.
    function automatic logic [31:0] calc_value(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        case (cmd)
            4'h1:    return a + b;
            4'h2:    return a - b;
            4'h5:    return a << b[4:0];
            4'h6:    return a >> b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit model_aborts(input int delay);
        return TIMEOUT_ON && (delay < 0 || delay >= TIMEOUT);
    endfunction

    function automatic logic [34:0] model_result(input logic [3:0] cmd, input int delay,
                                                 input logic [1:0] rsp, input logic [31:0] rdata);
        if (cmd == 4'h0) return 35'h0;
        if (model_aborts(delay)) return {2'b11, 32'h0, 1'b1};
        return {rsp, rdata, 1'b0};
    endfunction

    function automatic int model_latency(input logic [3:0] cmd, input int delay);
        if (cmd == 4'h0) return 0;
        if (model_aborts(delay)) return 2 + TIMEOUT;
        return 3 + delay;
    endfunction

    function automatic logic [71:0] model_wire(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        if (cmd == 4'h0) return 72'h0;
        return {cmd, a, 4'h0, b};
    endfunction

    // Offers one op, answers as calc1_top in WAIT cycle 'delay' (never if negative),
    // sprays ignored responses in IDLE/SEND cycles, and returns once res_valid is seen.
    task automatic run_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input int delay, input logic [1:0] rsp, input logic [31:0] rdata,
                          output logic acc_ready, output logic [71:0] wire_seq,
                          output logic quiet, output int lat, output logic [34:0] result);
        logic [3:0]  c1;
        logic [3:0]  c2;
        logic [31:0] d1;
        logic [31:0] d2;
        c1 = '0; c2 = '0; d1 = '0; d2 = '0;
        lat = -1; quiet = 1'b1; result = '0;
        op_valid = 1'b1; op_cmd = cmd; op_data1 = a; op_data2 = b;
        calc_resp_in = 2'($urandom_range(1, 3)); calc_data_in = $urandom;
        @(negedge c_clk);
        acc_ready = op_ready;
        @(posedge c_clk);
        for (int j = 0; j < BUDGET; j++) begin
            #1;
            op_valid = 1'b0;
            if (delay >= 0 && j == delay + 2) begin
                calc_resp_in = rsp; calc_data_in = rdata;
            end else if (j < 2) begin
                calc_resp_in = 2'($urandom_range(1, 3)); calc_data_in = $urandom;
            end else begin
                calc_resp_in = 2'b00; calc_data_in = $urandom;
            end
            @(negedge c_clk);
            if (j == 0) begin c1 = req_cmd_out; d1 = req_data_out; end
            if (j == 1) begin c2 = req_cmd_out; d2 = req_data_out; end
            if (j >= 2 && (req_cmd_out != 4'h0 || req_data_out != 32'h0)) quiet = 1'b0;
            if (res_valid) begin
                lat = j;
                result = {res_resp, res_data, res_timeout};
                break;
            end
            @(posedge c_clk);
        end
        wire_seq = {c1, d1, c2, d2};
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        calc_resp_in = 2'b00;
        @(posedge c_clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge c_clk);
        #1;
        n_cmp++;
        if ({op_ready, req_cmd_out, req_data_out, res_valid, res_resp, res_data, res_timeout, busy} !== 74'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_values got rdy=%b cmd=%h data=%h vld=%b resp=%b rdata=%h to=%b busy=%b want all zero",
                     op_ready, req_cmd_out, req_data_out, res_valid, res_resp, res_data, res_timeout, busy);
        end
        @(negedge c_clk);
        reset = 1'b1;
        @(posedge c_clk);
        #1;
        n_cmp++;
        if ({op_ready, busy, res_valid} !== 3'b100) begin
            n_bad++;
            $display("[TB] FAIL reset_release got rdy/busy/vld=%b want 100", {op_ready, busy, res_valid});
        end
    endtask

    task automatic test_add();
        logic acc; logic [71:0] w; logic q; int lat; logic [34:0] r;
        run_op(4'h1, 32'd5, 32'd7, 0, 2'b01, 32'd12, acc, w, q, lat, r);
        n_cmp++;
        if ({acc, q, w} !== {1'b1, 1'b1, 4'h1, 32'd5, 4'h0, 32'd7}) begin
            n_bad++;
            $display("[TB] FAIL add_wire got acc=%b quiet=%b seq=%h want 1 1 %h", acc, q, w, {4'h1, 32'd5, 4'h0, 32'd7});
        end
        n_cmp++;
        if (lat != 3) begin n_bad++; $display("[TB] FAIL add_latency got %0d want 3", lat); end
        n_cmp++;
        if (r !== {2'b01, 32'd12, 1'b0}) begin
            n_bad++; $display("[TB] FAIL add_result got %h want %h", r, {2'b01, 32'd12, 1'b0});
        end
        release_result();
    endtask

    task automatic test_sll();
        logic acc; logic [71:0] w; logic q; int lat; logic [34:0] r;
        run_op(4'h5, 32'd3, 32'd4, 1, 2'b01, 32'd48, acc, w, q, lat, r);
        n_cmp++;
        if ({acc, q, w} !== {1'b1, 1'b1, 4'h5, 32'd3, 4'h0, 32'd4}) begin
            n_bad++;
            $display("[TB] FAIL sll_wire got acc=%b quiet=%b seq=%h want 1 1 %h", acc, q, w, {4'h5, 32'd3, 4'h0, 32'd4});
        end
        n_cmp++;
        if (r !== {2'b01, 32'd48, 1'b0}) begin
            n_bad++; $display("[TB] FAIL sll_result got %h want %h", r, {2'b01, 32'd48, 1'b0});
        end
        release_result();
    endtask

    task automatic test_hold();
        logic acc; logic [71:0] w; logic q; int lat; logic [34:0] r;
        run_op(4'h2, 32'd9, 32'd2, 2, 2'b10, 32'd7, acc, w, q, lat, r);
        n_cmp++;
        if (lat != 5) begin n_bad++; $display("[TB] FAIL hold_latency got %0d want 5", lat); end
        for (int k = 0; k < 5; k++) begin
            @(posedge c_clk);
            #1;
            op_valid = 1'b1; op_cmd = 4'h1; op_data1 = 32'hA5A5_0001; op_data2 = 32'd1;
            calc_resp_in = 2'($urandom_range(1, 3)); calc_data_in = $urandom;
            @(negedge c_clk);
            n_cmp++;
            if ({res_valid, res_resp, res_data, res_timeout, op_ready, busy} !== {1'b1, 2'b10, 32'd7, 1'b0, 1'b0, 1'b1}) begin
                n_bad++;
                $display("[TB] FAIL hold_stable[%0d] got vld=%b resp=%b data=%h to=%b rdy=%b busy=%b want 1 10 7 0 0 1",
                         k, res_valid, res_resp, res_data, res_timeout, op_ready, busy);
            end
        end
        res_ready = 1'b1;
        @(posedge c_clk);
        #1;
        res_ready = 1'b0;
        @(negedge c_clk);
        n_cmp++;
        if ({op_ready, busy, res_valid} !== 3'b100) begin
            n_bad++; $display("[TB] FAIL hold_no_early_accept got rdy/busy/vld=%b want 100", {op_ready, busy, res_valid});
        end
        @(posedge c_clk);
        #1;
        op_valid = 1'b0;
        calc_resp_in = 2'b00;
        @(negedge c_clk);
        n_cmp++;
        if ({busy, req_cmd_out, req_data_out} !== {1'b1, 4'h1, 32'hA5A5_0001}) begin
            n_bad++;
            $display("[TB] FAIL hold_next_accept got busy=%b cmd=%h data=%h want 1 1 a5a50001", busy, req_cmd_out, req_data_out);
        end
        reset = 1'b0;
        @(posedge c_clk);
        #1;
        reset = 1'b1;
        repeat (3) @(negedge c_clk);
        n_cmp++;
        if ({res_valid, busy} !== 2'b00) begin
            n_bad++; $display("[TB] FAIL hold_dropped got vld/busy=%b want 00", {res_valid, busy});
        end
        @(posedge c_clk);
        #1;
    endtask

    task automatic test_nop();
        logic acc; logic [71:0] w; logic q; int lat; logic [34:0] r;
        run_op(4'h0, $urandom, $urandom, 0, 2'b01, 32'h1234, acc, w, q, lat, r);
        n_cmp++;
        if ({acc, q, w} !== {1'b1, 1'b1, 72'h0}) begin
            n_bad++; $display("[TB] FAIL nop_wire got acc=%b quiet=%b seq=%h want 1 1 0", acc, q, w);
        end
        n_cmp++;
        if (lat != 0) begin n_bad++; $display("[TB] FAIL nop_latency got %0d want 0", lat); end
        n_cmp++;
        if (r !== 35'h0) begin n_bad++; $display("[TB] FAIL nop_result got %h want 0", r); end
        release_result();
    endtask

    task automatic test_reset_in_wait();
        logic acc; logic [71:0] w; logic q; int lat; logic [34:0] r;
        op_valid = 1'b1; op_cmd = 4'h1; op_data1 = 32'd3; op_data2 = 32'd4;
        calc_resp_in = 2'b00;
        @(posedge c_clk);
        #1;
        op_valid = 1'b0;
        repeat (3) @(posedge c_clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL wait_busy got %b want 1", busy); end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({op_ready, req_cmd_out, req_data_out, res_valid, res_resp, res_data, res_timeout, busy} !== 74'h0) begin
            n_bad++;
            $display("[TB] FAIL wait_reset_values got rdy=%b cmd=%h data=%h vld=%b resp=%b rdata=%h to=%b busy=%b want all zero",
                     op_ready, req_cmd_out, req_data_out, res_valid, res_resp, res_data, res_timeout, busy);
        end
        @(negedge c_clk);
        reset = 1'b1;
        @(posedge c_clk);
        #1;
        calc_resp_in = 2'b01;
        @(negedge c_clk);
        n_cmp++;
        if ({res_valid, busy, op_ready} !== 3'b001) begin
            n_bad++; $display("[TB] FAIL wait_reset_dropped got vld/busy/rdy=%b want 001", {res_valid, busy, op_ready});
        end
        @(posedge c_clk);
        #1;
        run_op(4'h1, 32'd1, 32'd1, 1, 2'b01, 32'd2, acc, w, q, lat, r);
        n_cmp++;
        if (r !== {2'b01, 32'd2, 1'b0}) begin
            n_bad++; $display("[TB] FAIL after_reset_add got %h want %h", r, {2'b01, 32'd2, 1'b0});
        end
        release_result();
    endtask

`ifdef CALC1_REQ_TIMEOUT_EN
    task automatic test_timeout();
        logic acc; logic [71:0] w; logic q; int lat; logic [34:0] r;
        run_op(4'h1, 32'd10, 32'd20, -1, 2'b01, 32'd30, acc, w, q, lat, r);
        n_cmp++;
        if (lat != 2 + TIMEOUT) begin n_bad++; $display("[TB] FAIL timeout_latency got %0d want %0d", lat, 2 + TIMEOUT); end
        n_cmp++;
        if (r !== {2'b11, 32'h0, 1'b1}) begin
            n_bad++; $display("[TB] FAIL timeout_result got %h want %h", r, {2'b11, 32'h0, 1'b1});
        end
        calc_resp_in = 2'b01; calc_data_in = 32'd30;
        repeat (2) @(posedge c_clk);
        @(negedge c_clk);
        n_cmp++;
        if ({res_valid, res_resp, res_data, res_timeout} !== {1'b1, 2'b11, 32'h0, 1'b1}) begin
            n_bad++;
            $display("[TB] FAIL timeout_late_resp got vld=%b resp=%b data=%h to=%b want 1 11 0 1",
                     res_valid, res_resp, res_data, res_timeout);
        end
        release_result();
    endtask
`else
    task automatic test_timeout();
        logic acc; logic [71:0] w; logic q; int lat; logic [34:0] r;
        run_op(4'h1, 32'd10, 32'd20, 100, 2'b01, 32'd30, acc, w, q, lat, r);
        n_cmp++;
        if (lat != 103) begin n_bad++; $display("[TB] FAIL long_wait_latency got %0d want 103", lat); end
        n_cmp++;
        if (r !== {2'b01, 32'd30, 1'b0}) begin
            n_bad++; $display("[TB] FAIL long_wait_result got %h want %h", r, {2'b01, 32'd30, 1'b0});
        end
        release_result();
    endtask
`endif

    task automatic test_back_to_back();
        logic [3:0] cmds [5];
        logic acc; logic [71:0] w; logic q; int lat; logic [34:0] r;
        logic [3:0] cmd; logic [31:0] a; logic [31:0] b; logic [1:0] rsp; logic [31:0] rdata; int delay;
        cmds = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h6};
        for (int i = 0; i < 24; i++) begin
            cmd   = cmds[$urandom_range(0, 4)];
            a     = $urandom;
            b     = (cmd == 4'h5 || cmd == 4'h6) ? 32'($urandom_range(0, 31)) : $urandom;
            rsp   = 2'($urandom_range(1, 3));
            rdata = calc_value(cmd, a, b);
            delay = $urandom_range(0, 12);
            run_op(cmd, a, b, delay, rsp, rdata, acc, w, q, lat, r);
            n_cmp++;
            if ({acc, q, w} !== {1'b1, 1'b1, model_wire(cmd, a, b)}) begin
                n_bad++;
                $display("[TB] FAIL rand_wire[%0d] got acc=%b quiet=%b seq=%h want 1 1 %h", i, acc, q, w, model_wire(cmd, a, b));
            end
            n_cmp++;
            if (lat != model_latency(cmd, delay)) begin
                n_bad++; $display("[TB] FAIL rand_latency[%0d] got %0d want %0d", i, lat, model_latency(cmd, delay));
            end
            n_cmp++;
            if (r !== model_result(cmd, delay, rsp, rdata)) begin
                n_bad++; $display("[TB] FAIL rand_result[%0d] got %h want %h", i, r, model_result(cmd, delay, rsp, rdata));
            end
            release_result();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got no finish want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_sll();
        test_hold();
        test_nop();
        test_reset_in_wait();
        test_timeout();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
